othello_move_checker: RTL and testbench

//  Full-move legality checker for the Othello engine. Given a target square and the player
//  to move, scans all 8 rays through the board RAM and reports which directions capture.

---
 rtl/othello_pkg.sv | 50 +++++
 rtl/othello_ray_stepper.sv | 40 ++++
 rtl/othello_move_checker.sv | 204 ++++++++++++++++++++
 tb/tb_othello_move_checker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared encodings for the Othello move checker: cell values, ray directions,
// per-direction step deltas and the checker FSM state encoding.
// Pure definitions, no logic; imported by the checker and its ray stepper.
package othello_pkg;

    // Board RAM cell encodings; RSVD is read back as if the square were empty
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_RSVD  = 2'b11;

    // Direction indices, clockwise from north; bit d of dir_mask maps to index d
    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ORIGIN,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_NEXT_DIR,
        S_DONE
    } state_t;

    // Column delta for a direction, two's complement in 2 bits (-1, 0, +1)
    function automatic logic signed [1:0] dir_dx(input logic [2:0] d);
        case (d)
            DIR_NE, DIR_E, DIR_SE: return 2'sb01;
            DIR_SW, DIR_W, DIR_NW: return 2'sb11;
            default:               return 2'sb00;
        endcase
    endfunction

    // Row delta for a direction; row 0 is the top, so north is -1
    function automatic logic signed [1:0] dir_dy(input logic [2:0] d);
        case (d)
            DIR_N, DIR_NE, DIR_NW: return 2'sb11;
            DIR_SE, DIR_S, DIR_SW: return 2'sb01;
            default:               return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/othello_ray_stepper.sv
// Purpose: advance a board position one square along direction dir and flag off-board.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: pos_x/pos_y signed position in, dir direction index in,
//        next_x/next_y stepped position, off_board (stepped square outside board), addr RAM address of it.
module othello_ray_stepper
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = 4,
    parameter int ADDR_W    = 8
) (
    input  logic signed [COORD_W:0] pos_x,
    input  logic signed [COORD_W:0] pos_y,
    input  logic [2:0]              dir,
    output logic signed [COORD_W:0] next_x,
    output logic signed [COORD_W:0] next_y,
    output logic                    off_board,
    output logic [ADDR_W-1:0]       addr
);

    localparam logic signed [COORD_W:0] DIM_S = (COORD_W+1)'(BOARD_DIM);

    logic signed [1:0] dx;
    logic signed [1:0] dy;

    always_comb begin
        dx = dir_dx(dir);
        dy = dir_dy(dir);
        // Sign-extend the 2-bit deltas to the position width
        next_x = pos_x + {{(COORD_W-1){dx[1]}}, dx};
        next_y = pos_y + {{(COORD_W-1){dy[1]}}, dy};
        // Bounds are tested per axis so a ray can never wrap onto the next row
        off_board = next_x[COORD_W] | next_y[COORD_W] |
                    (next_x >= DIM_S) | (next_y >= DIM_S);
        // Only meaningful when off_board is clear
        addr = ADDR_W'(next_y[COORD_W-1:0]) * ADDR_W'(BOARD_DIM) +
               ADDR_W'(next_x[COORD_W-1:0]);
    end

endmodule

// File: rtl/othello_move_checker.sv
// Purpose: decide move legality at (square_x, square_y) by probing all 8 rays in board RAM.
// Latency: one RAM probe per RAM_LAT+1 cycles, plus one cycle per ray start and a final done cycle.
// Backpressure: start is only accepted in IDLE; requests while a check is running are dropped.
// Ports: clock/reset (async active-low); start,square_x,square_y,player request; ram_re,ram_addr,
//        ram_rdata board RAM read port; busy,done status; legal,dir_mask result held until next start.
module othello_move_checker
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = 4,
    parameter int ADDR_W    = 8,
    parameter int RAM_LAT   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] square_x,
    input  logic [COORD_W-1:0] square_y,
    input  logic               player,
    output logic               ram_re,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [1:0]         ram_rdata,
    output logic               busy,
    output logic               done,
    output logic               legal,
    output logic [7:0]         dir_mask
);

    localparam logic [COORD_W:0]   DIM_U     = (COORD_W+1)'(BOARD_DIM);
    localparam logic [COORD_W-1:0] RUN_MAX   = COORD_W'(BOARD_DIM - 1);
    localparam logic [1:0]         WAIT_INIT = 2'(RAM_LAT > 1 ? RAM_LAT - 2 : 0);

    state_t                  state;
    logic [COORD_W-1:0]      org_x;
    logic [COORD_W-1:0]      org_y;
    logic                    player_q;
    logic signed [COORD_W:0] pos_x;
    logic signed [COORD_W:0] pos_y;
    logic [2:0]              dir;
    logic [COORD_W-1:0]      run;
    logic [1:0]              wait_cnt;
    logic                    origin_probe;   // current probe is the target square itself

    logic signed [COORD_W:0] org_sx;
    logic signed [COORD_W:0] org_sy;
    logic signed [COORD_W:0] step_in_x;
    logic signed [COORD_W:0] step_in_y;
    logic signed [COORD_W:0] step_x;
    logic signed [COORD_W:0] step_y;
    logic                    step_off;
    logic [ADDR_W-1:0]       step_addr;
    logic [ADDR_W-1:0]       org_addr;
    logic                    org_off;
    logic [1:0]              own_cell;
    logic [1:0]              opp_cell;
    logic                    cell_occupied;
    logic                    last_dir;

    always_comb begin
        org_sx        = {1'b0, org_x};
        org_sy        = {1'b0, org_y};
        // A new ray always starts from the origin, later steps continue from pos
        step_in_x     = (state == S_NEXT_DIR) ? org_sx : pos_x;
        step_in_y     = (state == S_NEXT_DIR) ? org_sy : pos_y;
        org_addr      = ADDR_W'(org_y) * ADDR_W'(BOARD_DIM) + ADDR_W'(org_x);
        org_off       = ({1'b0, org_x} >= DIM_U) | ({1'b0, org_y} >= DIM_U);
        own_cell      = player_q ? CELL_WHITE : CELL_BLACK;
        opp_cell      = player_q ? CELL_BLACK : CELL_WHITE;
        // Reserved cells count as empty, so only real pieces block the target
        cell_occupied = (ram_rdata == CELL_BLACK) | (ram_rdata == CELL_WHITE);
        last_dir      = (dir == DIR_NW);
    end

    othello_ray_stepper #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W),
        .ADDR_W    (ADDR_W)
    ) u_stepper (
        .pos_x     (step_in_x),
        .pos_y     (step_in_y),
        .dir       (dir),
        .next_x    (step_x),
        .next_y    (step_y),
        .off_board (step_off),
        .addr      (step_addr)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            org_x        <= '0;
            org_y        <= '0;
            player_q     <= 1'b0;
            pos_x        <= '0;
            pos_y        <= '0;
            dir          <= '0;
            run          <= '0;
            wait_cnt     <= '0;
            origin_probe <= 1'b0;
            ram_re       <= 1'b0;
            ram_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            legal        <= 1'b0;
            dir_mask     <= '0;
        end else begin
            done   <= 1'b0;
            ram_re <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        org_x    <= square_x;
                        org_y    <= square_y;
                        player_q <= player;
                        dir_mask <= '0;
                        legal    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ORIGIN;
                    end
                end
                S_ORIGIN: begin
                    if (org_off) begin
                        state <= S_DONE;
                    end else begin
                        ram_re       <= 1'b1;
                        ram_addr     <= org_addr;
                        origin_probe <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (RAM_LAT == 1) begin
                        state <= S_EVAL;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) state <= S_EVAL;
                    else                  wait_cnt <= wait_cnt - 2'd1;
                end
                S_EVAL: begin
                    if (origin_probe) begin
                        origin_probe <= 1'b0;
                        if (cell_occupied) begin
                            state <= S_DONE;
                        end else begin
                            dir   <= DIR_N;
                            state <= S_NEXT_DIR;
                        end
                    end else if (ram_rdata == opp_cell) begin
                        if (run != RUN_MAX) run <= run + COORD_W'(1);
                        if (step_off) begin
                            if (last_dir) state <= S_DONE;
                            else begin
                                dir   <= dir + 3'd1;
                                state <= S_NEXT_DIR;
                            end
                        end else begin
                            pos_x    <= step_x;
                            pos_y    <= step_y;
                            ram_re   <= 1'b1;
                            ram_addr <= step_addr;
                            state    <= S_ISSUE;
                        end
                    end else begin
                        // Own piece closes the ray only if it bracketed at least one opponent
                        if ((ram_rdata == own_cell) && (run != '0)) dir_mask[dir] <= 1'b1;
                        if (last_dir) state <= S_DONE;
                        else begin
                            dir   <= dir + 3'd1;
                            state <= S_NEXT_DIR;
                        end
                    end
                end
                S_NEXT_DIR: begin
                    run <= '0;
                    if (step_off) begin
                        if (last_dir) state <= S_DONE;
                        else begin
                            dir   <= dir + 3'd1;
                            state <= S_NEXT_DIR;
                        end
                    end else begin
                        pos_x    <= step_x;
                        pos_y    <= step_y;
                        ram_re   <= 1'b1;
                        ram_addr <= step_addr;
                        state    <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    legal <= |dir_mask;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_othello_move_checker.sv
module tb_othello_move_checker;

    typedef struct {
        int         inst;
        int         board;
        int         x;
        int         y;
        int         p;
        logic [7:0] mask;
        logic       lg;
        int         probes;
        bit         gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s [2];
    logic [3:0] sx [2];
    logic [3:0] sy [2];
    logic       pl [2];
    logic       re [2];
    logic [7:0] addr [2];
    logic [1:0] rdata [2];
    logic       busy [2];
    logic       done_o [2];
    logic       legal [2];
    logic [7:0] mask_o [2];

    logic [1:0] mem [2][256];
    logic [1:0] pipe [2][4];

    int bd [2]  = '{8, 6};
    int lat [2] = '{1, 3};
    int dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int probe_cnt [2];
    int last_probe [2];
    int min_gap [2];
    int done_cnt [2];
    int watch_addr [2];
    bit saw_watch [2];

    vec_t vecs [11];

    always #5 clk = ~clk;

    othello_move_checker #(.BOARD_DIM(8), .COORD_W(4), .ADDR_W(8), .RAM_LAT(1)) dut_a (
        .clock(clk), .reset(rst_n), .start(start_s[0]), .square_x(sx[0]), .square_y(sy[0]),
        .player(pl[0]), .ram_re(re[0]), .ram_addr(addr[0]), .ram_rdata(rdata[0]),
        .busy(busy[0]), .done(done_o[0]), .legal(legal[0]), .dir_mask(mask_o[0]));

    othello_move_checker #(.BOARD_DIM(6), .COORD_W(4), .ADDR_W(8), .RAM_LAT(3)) dut_b (
        .clock(clk), .reset(rst_n), .start(start_s[1]), .square_x(sx[1]), .square_y(sy[1]),
        .player(pl[1]), .ram_re(re[1]), .ram_addr(addr[1]), .ram_rdata(rdata[1]),
        .busy(busy[1]), .done(done_o[1]), .legal(legal[1]), .dir_mask(mask_o[1]));

    // Board RAM models: data appears RAM_LAT cycles after the strobe cycle; any
    // cycle without a strobe pushes a reserved value so unstrobed reads are visible.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 3; k > 0; k--) pipe[i][k] <= pipe[i][k-1];
            pipe[i][0] <= re[i] ? mem[i][addr[i]] : 2'b11;
        end
    end
    assign rdata[0] = pipe[0][0];
    assign rdata[1] = pipe[1][2];

    // Probe and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (re[i] === 1'b1) begin
                probe_cnt[i]++;
                if (last_probe[i] >= 0 && (cyc - last_probe[i]) < min_gap[i])
                    min_gap[i] = cyc - last_probe[i];
                last_probe[i] = cyc;
                if (int'(addr[i]) == watch_addr[i]) saw_watch[i] = 1'b1;
            end
            if (done_o[i] === 1'b1) done_cnt[i]++;
        end
        cyc++;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic put(input int i, input int x, input int y, input int v);
        mem[i][y*bd[i] + x] = 2'(v);
    endtask

    // 0: standard opening centred on the board, 1: row-wrap trap, 2: multi-direction
    task automatic build(input int i, input int id);
        int c;
        c = bd[i] / 2 - 1;
        for (int a = 0; a < 256; a++) mem[i][a] = 2'b00;
        case (id)
            0: begin
                put(i, c, c, 2); put(i, c+1, c+1, 2);
                put(i, c+1, c, 1); put(i, c, c+1, 1);
            end
            1: begin
                put(i, 0, 1, 2); put(i, 1, 1, 1);
            end
            default: begin
                put(i, 3, 2, 2); put(i, 3, 3, 2); put(i, 2, 3, 2);
                put(i, 4, 2, 1); put(i, 4, 4, 1); put(i, 2, 4, 1); put(i, 1, 2, 1);
            end
        endcase
    endtask

    // Reference: walk each ray square by square over the board array
    function automatic void model(input int i, input int x, input int y, input int p,
                                  output logic [7:0] m, output int probes);
        int b, cx, cy, run;
        logic [1:0] own, opp, v;
        b = bd[i];
        m = 8'h00;
        probes = 0;
        if (x >= b || y >= b) return;
        probes = 1;
        v = mem[i][y*b + x];
        if (v == 2'b01 || v == 2'b10) return;
        own = (p != 0) ? 2'b10 : 2'b01;
        opp = (p != 0) ? 2'b01 : 2'b10;
        for (int d = 0; d < 8; d++) begin
            cx = x + dxt[d];
            cy = y + dyt[d];
            run = 0;
            while (cx >= 0 && cx < b && cy >= 0 && cy < b) begin
                probes++;
                v = mem[i][cy*b + cx];
                if (v == opp) begin
                    run++;
                    cx += dxt[d];
                    cy += dyt[d];
                end else begin
                    if (v == own && run > 0) m[d] = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic do_run(input int i, input int x, input int y, input int p,
                          output logic [7:0] m, output logic lg);
        int budget;
        bit ok;
        budget = 1 + (lat[i] + 1) * (1 + 8 * (bd[i] - 1)) + 9 + 10;
        @(negedge clk);
        probe_cnt[i] = 0; last_probe[i] = -1; min_gap[i] = 1000;
        saw_watch[i] = 1'b0; done_cnt[i] = 0;
        sx[i] = 4'(x); sy[i] = 4'(y); pl[i] = p[0]; start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        check($sformatf("busy_after_start_i%0d", i), int'(busy[i]), 1);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_o[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("done_seen_i%0d", i), int'(ok), 1);
        m = mask_o[i];
        lg = legal[i];
        @(negedge clk);
        check($sformatf("done_one_cycle_i%0d", i), int'(done_o[i]), 0);
        check($sformatf("busy_after_done_i%0d", i), int'(busy[i]), 0);
    endtask

    initial begin
        vec_t v;
        logic [7:0] m, mexp;
        logic lg;
        int i, b, x, y, p, pexp, r;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; sx[k] = '0; sy[k] = '0; pl[k] = 1'b0;
            watch_addr[k] = 255; probe_cnt[k] = 0; last_probe[k] = -1;
            min_gap[k] = 1000; done_cnt[k] = 0; saw_watch[k] = 1'b0;
            for (int a = 0; a < 4; a++) pipe[k][a] = 2'b00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_busy_i%0d", k), int'(busy[k]), 0);
            check($sformatf("reset_done_i%0d", k), int'(done_o[k]), 0);
            check($sformatf("reset_legal_i%0d", k), int'(legal[k]), 0);
            check($sformatf("reset_mask_i%0d", k), int'(mask_o[k]), 0);
            check($sformatf("reset_re_i%0d", k), int'(re[k]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // inst, board, x, y, player, mask, legal, probes, probe spacing check
        vecs[0]  = '{0, 0, 3, 2, 0, 8'h10, 1'b1, 10, 1'b1};
        vecs[1]  = '{0, 0, 3, 3, 0, 8'h00, 1'b0, 1,  1'b0};
        vecs[2]  = '{0, 1, 7, 0, 0, 8'h00, 1'b0, 4,  1'b0};
        vecs[3]  = '{0, 2, 2, 2, 0, 8'h1C, 1'b1, 12, 1'b1};
        vecs[4]  = '{1, 0, 2, 1, 0, 8'h10, 1'b1, 10, 1'b1};
        vecs[5]  = '{1, 1, 5, 0, 0, 8'h00, 1'b0, 4,  1'b0};
        vecs[6]  = '{1, 2, 2, 2, 0, 8'h1C, 1'b1, 12, 1'b1};
        vecs[7]  = '{0, 0, 9, 0, 0, 8'h00, 1'b0, 0,  1'b0};
        vecs[8]  = '{0, 0, 4, 2, 1, 8'h10, 1'b1, 10, 1'b1};
        vecs[9]  = '{1, 0, 0, 6, 0, 8'h00, 1'b0, 0,  1'b0};
        vecs[10] = '{1, 0, 2, 2, 0, 8'h00, 1'b0, 1,  1'b0};

        for (int k = 0; k < 11; k++) begin
            v = vecs[k];
            build(v.inst, v.board);
            watch_addr[v.inst] = (v.board == 1) ? bd[v.inst] : 255;
            do_run(v.inst, v.x, v.y, v.p, m, lg);
            check($sformatf("vec%0d_mask", k), int'(m), int'(v.mask));
            check($sformatf("vec%0d_legal", k), int'(lg), int'(v.lg));
            check($sformatf("vec%0d_probes", k), probe_cnt[v.inst], v.probes);
            if (v.board == 1)
                check($sformatf("vec%0d_no_wrap_probe", k), int'(saw_watch[v.inst]), 0);
            if (v.gap)
                check($sformatf("vec%0d_probe_spacing", k), min_gap[v.inst], lat[v.inst] + 1);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_legal_held", k), int'(legal[v.inst]), int'(v.lg));
            watch_addr[v.inst] = 255;
        end

        // A second start while the first check runs must be dropped
        build(0, 0);
        @(negedge clk);
        done_cnt[0] = 0;
        sx[0] = 4'd3; sy[0] = 4'd2; pl[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        sx[0] = 4'd3; sy[0] = 4'd3; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (150) @(negedge clk);
        check("busy_start_done_count", done_cnt[0], 1);
        check("busy_start_mask", int'(mask_o[0]), 8'h10);
        check("busy_start_legal", int'(legal[0]), 1);

        // Reset in the middle of a scan, after the E ray has already captured
        build(1, 2);
        @(negedge clk);
        done_cnt[1] = 0;
        sx[1] = 4'd2; sy[1] = 4'd2; pl[1] = 1'b0; start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        repeat (40) @(negedge clk);
        check("midscan_busy_before_reset", int'(busy[1]), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midscan_reset_busy", int'(busy[1]), 0);
        check("midscan_reset_done", int'(done_o[1]), 0);
        check("midscan_reset_legal", int'(legal[1]), 0);
        check("midscan_reset_mask", int'(mask_o[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("midscan_no_done_pulse", done_cnt[1], 0);
        do_run(1, 2, 2, 0, m, lg);
        check("after_reset_mask", int'(m), 8'h1C);
        check("after_reset_legal", int'(lg), 1);

        // Random boards against the reference walk
        for (int n = 0; n < 60; n++) begin
            i = $urandom_range(0, 1);
            b = bd[i];
            for (int a = 0; a < 256; a++) begin
                r = $urandom_range(0, 99);
                mem[i][a] = (r < 40) ? 2'b00 : (r < 70) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
            end
            x = $urandom_range(0, b + 1);
            y = $urandom_range(0, b + 1);
            p = $urandom_range(0, 1);
            if (x < b && y < b) begin
                if ($urandom_range(0, 9) < 8 || mem[i][y*b + x] == 2'b11)
                    mem[i][y*b + x] = 2'b00;
            end
            model(i, x, y, p, mexp, pexp);
            do_run(i, x, y, p, m, lg);
            check($sformatf("rand%0d_mask", n), int'(m), int'(mexp));
            check($sformatf("rand%0d_legal", n), int'(lg), int'(mexp != 8'h00));
            check($sformatf("rand%0d_probes", n), probe_cnt[i], pexp);
            if (pexp >= 2)
                check($sformatf("rand%0d_spacing_min", n), int'(min_gap[i] >= lat[i] + 1), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
